// File: rtl/imem_fetch_arbiter_pkg.sv
// Shared types and constants for the instruction-memory fetch arbiter.
// The package keeps the RV32I_definitions name so other core files can share it.
package RV32I_definitions;

    typedef enum logic {ARB_BOOT, ARB_RUN} imem_arb_state_t;
    typedef enum logic {GNT_FETCH, GNT_LOAD} imem_gnt_t;

    localparam logic [31:0] RV32I_NOP = 32'h00000013;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/imem_fetch_arbiter_pick.sv
// Two-way grant picker for the IMEM port: loader wins unless it was granted last.
// A caller that always presents GNT_FETCH as last grant gets fixed loader priority.
module imem_arb_pick
    import RV32I_definitions::*;
(
    input  logic      req_fetch_i,
    input  logic      req_load_i,
    input  imem_gnt_t last_gnt_i,
    output logic      gnt_fetch_o,
    output logic      gnt_load_o
);

    logic load_turn;

    always_comb begin
        load_turn   = (last_gnt_i == GNT_FETCH);
        gnt_load_o  = req_load_i & (~req_fetch_i | load_turn);
        gnt_fetch_o = req_fetch_i & (~req_load_i | ~load_turn);
    end

endmodule

// File: rtl/imem_fetch_arbiter.sv
// Shares the single instruction-SRAM port between the fetch stage and the boot loader.
// Define IMEM_ARB_ROUND_ROBIN_EN to alternate grants on contention instead of loader priority.
module imem_fetch_arbiter
    import RV32I_definitions::*;
#(
    parameter int unsigned IMEM_WADDR_WIDTH = 11,
    parameter int unsigned IMEM_DATA_DEPTH  = 2048,
    parameter logic [31:0] NOP_INSTR        = RV32I_NOP
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        if_req,
    input  logic [31:0]                 if_addr,
    output logic                        if_gnt,
    output logic                        if_rvalid,
    output logic [31:0]                 if_rdata,
    output logic                        if_misalign,
    input  logic                        ld_valid,
    input  logic [IMEM_WADDR_WIDTH-1:0] ld_waddr,
    input  logic [31:0]                 ld_wdata,
    input  logic                        ld_last,
    output logic                        ld_ready,
    output logic                        core_stall,
    output logic [15:0]                 ld_count,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [IMEM_WADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]                 mem_wdata,
    input  logic [31:0]                 mem_rdata
);

    imem_arb_state_t state_q, state_d;
    imem_gnt_t       last_gnt;

    logic        rvalid_q;
    logic        misalign_q;
    logic        oor_q;
    logic [31:0] rdata_q;
    logic [15:0] count_q;

    logic run;
    logic arb_fetch, arb_load;
    logic fetch_gnt, load_gnt;
    logic fetch_in_range, load_in_range;

    assign run            = (state_q == ARB_RUN);
    assign fetch_in_range = ({2'b00, if_addr[31:2]} < IMEM_DATA_DEPTH);
    assign load_in_range  = (32'(ld_waddr) < IMEM_DATA_DEPTH);

    imem_arb_pick u_pick (
        .req_fetch_i (if_req & run),
        .req_load_i  (ld_valid & run),
        .last_gnt_i  (last_gnt),
        .gnt_fetch_o (arb_fetch),
        .gnt_load_o  (arb_load)
    );

`ifdef IMEM_ARB_ROUND_ROBIN_EN
    // Only RUN-phase grants move the pointer, so the first contention after boot goes to the loader.
    imem_gnt_t last_q, last_d;

    always_comb begin
        last_d = last_q;
        if (arb_load)
            last_d = GNT_LOAD;
        else if (arb_fetch)
            last_d = GNT_FETCH;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            last_q <= GNT_FETCH;
        else
            last_q <= last_d;
    end

    assign last_gnt = last_q;
`else
    assign last_gnt = GNT_FETCH;
`endif

    always_comb begin
        state_d   = state_q;
        fetch_gnt = 1'b0;
        load_gnt  = 1'b0;
        ld_ready  = 1'b0;
        if (resetn) begin
            if (run) begin
                fetch_gnt = arb_fetch;
                load_gnt  = arb_load;
                ld_ready  = arb_load;
            end else begin
                load_gnt = ld_valid;
                ld_ready = 1'b1;
                if (ld_valid && ld_last)
                    state_d = ARB_RUN;
            end
        end
    end

    assign if_gnt     = fetch_gnt;
    assign mem_en     = (fetch_gnt & fetch_in_range) | (load_gnt & load_in_range);
    assign mem_we     = load_gnt & load_in_range;
    assign mem_addr   = load_gnt ? ld_waddr : if_addr[IMEM_WADDR_WIDTH+1:2];
    assign mem_wdata  = ld_wdata;
    assign core_stall = ~run;
    assign ld_count   = count_q;

    // Read data is forwarded straight from the SRAM in the return cycle and held afterwards.
    assign if_rvalid   = rvalid_q;
    assign if_misalign = rvalid_q & misalign_q;
    assign if_rdata    = rvalid_q ? (oor_q ? NOP_INSTR : mem_rdata) : rdata_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ARB_BOOT;
            rvalid_q   <= 1'b0;
            misalign_q <= 1'b0;
            oor_q      <= 1'b0;
            rdata_q    <= '0;
            count_q    <= '0;
        end else begin
            state_q  <= state_d;
            rvalid_q <= fetch_gnt;
            if (fetch_gnt) begin
                misalign_q <= |if_addr[1:0];
                oor_q      <= ~fetch_in_range;
            end
            if (rvalid_q)
                rdata_q <= if_rdata;
            if (load_gnt)
                count_q <= sat_inc16(count_q);
        end
    end

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Randomised self-checking bench for imem_fetch_arbiter with an SRAM model and a transaction-level reference.
// Honours IMEM_ARB_ROUND_ROBIN_EN the same way as the design.
module tb_imem_fetch_arbiter;

    localparam int AW    = 11;
    localparam int DEPTH = 2048;
    localparam logic [31:0] NOP = 32'h00000013;
`ifdef IMEM_ARB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          resetn;
    logic          if_req;
    logic [31:0]   if_addr;
    logic          if_gnt, if_rvalid, if_misalign;
    logic [31:0]   if_rdata;
    logic          ld_valid, ld_last, ld_ready, core_stall;
    logic [AW-1:0] ld_waddr;
    logic [31:0]   ld_wdata;
    logic [15:0]   ld_count;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    int compared = 0;
    int mismatched = 0;

    // Reference state: what memory should hold and what the core should see.
    logic [31:0] refMem [DEPTH];
    bit          booted;
    int          refCount;
    bit          pendValid;
    logic [31:0] pendData;
    bit          pendMis;
    logic [31:0] lastData;
    bit          lastWasLoad;

    logic [31:0] sram [DEPTH];

    always #5 clk = ~clk;

    imem_fetch_arbiter dut (
        .clk         (clk),
        .resetn      (resetn),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_gnt      (if_gnt),
        .if_rvalid   (if_rvalid),
        .if_rdata    (if_rdata),
        .if_misalign (if_misalign),
        .ld_valid    (ld_valid),
        .ld_waddr    (ld_waddr),
        .ld_wdata    (ld_wdata),
        .ld_last     (ld_last),
        .ld_ready    (ld_ready),
        .core_stall  (core_stall),
        .ld_count    (ld_count),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    // Synchronous single-port SRAM with one cycle of read latency.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we)
                sram[mem_addr] <= mem_wdata;
            else
                mem_rdata <= sram[mem_addr];
        end
    end

    function automatic logic [31:0] initWord(input int i);
        return 32'hC0DE0000 ^ (32'(i) * 32'h01000193);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, wanted %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit req, input logic [31:0] addr, input bit lv,
                                 input logic [AW-1:0] wa, input logic [31:0] wd, input bit last);
        if_req   = req;
        if_addr  = addr;
        ld_valid = lv;
        ld_waddr = wa;
        ld_wdata = wd;
        ld_last  = last;
    endtask

    task automatic modelReset();
        booted      = 1'b0;
        refCount    = 0;
        pendValid   = 1'b0;
        pendData    = '0;
        pendMis     = 1'b0;
        lastData    = '0;
        lastWasLoad = 1'b0;
    endtask

    // Called just after a rising edge with inputs already applied; checks mid-cycle, then advances one edge.
    task automatic runCycle();
        bit expF, expL, fIn, lIn, wasBooted;
        logic [31:0] wordIdx;
        #3;
        wordIdx = {2'b00, if_addr[31:2]};
        fIn = (wordIdx < DEPTH);
        lIn = (32'(ld_waddr) < DEPTH);
        if (!booted) begin
            expL = ld_valid;
            expF = 1'b0;
        end else begin
            expL = ld_valid && !(if_req && RR_EN && lastWasLoad);
            expF = if_req && !expL;
        end
        checkOutput("if_gnt", {31'b0, if_gnt}, {31'b0, expF});
        checkOutput("ld_ready", {31'b0, ld_ready}, {31'b0, (booted ? expL : 1'b1)});
        checkOutput("core_stall", {31'b0, core_stall}, {31'b0, !booted});
        checkOutput("ld_count", {16'b0, ld_count}, 32'(refCount));
        checkOutput("if_rvalid", {31'b0, if_rvalid}, {31'b0, pendValid});
        checkOutput("if_rdata", if_rdata, pendValid ? pendData : lastData);
        checkOutput("if_misalign", {31'b0, if_misalign}, {31'b0, pendValid && pendMis});
        checkOutput("mem_en", {31'b0, mem_en}, {31'b0, (expF && fIn) || (expL && lIn)});
        checkOutput("mem_we", {31'b0, mem_we}, {31'b0, expL && lIn});
        if (expL && lIn) begin
            checkOutput("mem_addr_wr", 32'(mem_addr), 32'(ld_waddr));
            checkOutput("mem_wdata", mem_wdata, ld_wdata);
        end else if (expF && fIn) begin
            checkOutput("mem_addr_rd", 32'(mem_addr), wordIdx);
        end
        @(posedge clk);
        wasBooted = booted;
        if (pendValid)
            lastData = pendData;
        pendValid = expF;
        pendMis   = (if_addr[1:0] != 2'b00);
        pendData  = fIn ? refMem[wordIdx[AW-1:0]] : NOP;
        if (expL) begin
            if (refCount < 65535)
                refCount++;
            if (lIn)
                refMem[ld_waddr] = ld_wdata;
            if (!booted && ld_last)
                booted = 1'b1;
        end
        if (wasBooted && (expL || expF))
            lastWasLoad = expL;
        #1;
    endtask

    task automatic randomCycles(input int n, input int lastOdds);
        logic [31:0] addr;
        int r;
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0)
                addr = 32'h2000 + (32'($urandom_range(0, 255)) << 2);
            else
                addr = (32'($urandom_range(0, 15)) << 2) | ((r == 1) ? 32'($urandom_range(1, 3)) : 32'd0);
            applyStimulus($urandom_range(0, 3) != 0, addr, $urandom_range(0, 2) == 0,
                          AW'($urandom_range(0, 15)), $urandom, $urandom_range(0, lastOdds) == 0);
            runCycle();
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            sram[i]   = initWord(i);
            refMem[i] = initWord(i);
        end
        mem_rdata = '0;
        resetn = 1'b0;
        applyStimulus(1'b1, 32'h8, 1'b1, '0, 32'h1234_5678, 1'b0);
        modelReset();
        repeat (3) @(posedge clk);
        #2;
        checkOutput("rst_if_gnt", {31'b0, if_gnt}, 32'd0);
        checkOutput("rst_ld_ready", {31'b0, ld_ready}, 32'd0);
        checkOutput("rst_mem_en", {31'b0, mem_en}, 32'd0);
        checkOutput("rst_mem_we", {31'b0, mem_we}, 32'd0);
        checkOutput("rst_core_stall", {31'b0, core_stall}, 32'd1);
        checkOutput("rst_if_rvalid", {31'b0, if_rvalid}, 32'd0);
        checkOutput("rst_if_rdata", if_rdata, 32'd0);
        checkOutput("rst_ld_count", {16'b0, ld_count}, 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // Boot with the fetch stage already requesting.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'h0, 1'b1, AW'(i), (i == 2) ? 32'hDEADBEEF : $urandom, i == 3);
            runCycle();
        end
        checkOutput("boot_count", {16'b0, ld_count}, 32'd4);
        checkOutput("boot_stall", {31'b0, core_stall}, 32'd0);

        applyStimulus(1'b1, 32'h8, 1'b0, '0, '0, 1'b0);
        runCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, '0, '0, 1'b0);
        runCycle();
        checkOutput("fetch_hold_data", if_rdata, 32'hDEADBEEF);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'(i * 4), 1'b0, '0, '0, 1'b0);
            runCycle();
        end
        applyStimulus(1'b1, 32'h2000, 1'b0, '0, '0, 1'b0);
        runCycle();
        applyStimulus(1'b1, 32'h6, 1'b0, '0, '0, 1'b0);
        runCycle();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'h4, 1'b1, AW'(8 + i), $urandom, 1'b0);
            runCycle();
        end
        applyStimulus(1'b0, 32'h0, 1'b0, '0, '0, 1'b0);
        runCycle();

        randomCycles(400, 1);

        // Reset arrives while a fetch return is in flight.
        applyStimulus(1'b1, 32'h4, 1'b0, '0, '0, 1'b0);
        runCycle();
        resetn = 1'b0;
        #1;
        checkOutput("midrst_rvalid", {31'b0, if_rvalid}, 32'd0);
        checkOutput("midrst_stall", {31'b0, core_stall}, 32'd1);
        checkOutput("midrst_count", {16'b0, ld_count}, 32'd0);
        modelReset();
        applyStimulus(1'b0, 32'h0, 1'b0, '0, '0, 1'b0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        runCycle();

        randomCycles(400, 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
